// File: rtl/fb_fetch_arbiter.sv
// Framebuffer memory arbiter: copies one 1bpp source row per fetch into a
// ping-pong line buffer, and gives the frame loader the leftover idle cycles.
module fb_fetch_arbiter #(
  parameter int WORDS_PER_ROW = 10,
  parameter int ROWS          = 120
) (
  input  logic        CLK_50,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        fetch_req,
  input  logic [6:0]  fetch_row,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [10:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        wr_frame_done,
  output logic [11:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        lb_wr_en,
  output logic [4:0]  lb_wr_addr,
  output logic [15:0] lb_wr_data,
  output logic        display_page,
  output logic        fetch_busy,
  output logic        fetch_overrun
);

  localparam logic [1:0]  IDLE        = 2'd0;
  localparam logic [1:0]  FETCH       = 2'd1;
  localparam logic [1:0]  DRAIN       = 2'd2;
  localparam logic [7:0]  ROWS_L      = 8'(ROWS);
  localparam logic [10:0] WPR_L       = 11'(WORDS_PER_ROW);
  localparam logic [10:0] WORDS_TOTAL = 11'(ROWS * WORDS_PER_ROW);
  localparam logic [3:0]  LAST_K      = 4'(WORDS_PER_ROW - 1);

  logic [1:0]  state;
  logic [3:0]  k;
  logic [3:0]  lb_idx;
  logic        lb_en_q;
  logic [10:0] row_base;
  logic        fetch_page;
  logic        bank;
  logic        pending;
  logic [6:0]  pending_row;
  logic        swap_pending;
  logic [6:0]  start_row;
  logic        start_req;
  logic        start_ok;
  logic [10:0] start_base;
  logic        wr_accept;

  // A latched request always wins over a fresh strobe; out-of-range rows are dropped
  assign start_row  = pending ? pending_row : fetch_row;
  assign start_req  = ((state == IDLE) && (pending || fetch_req)) ||
                      ((state == DRAIN) && pending);
  assign start_ok   = start_req && ({1'b0, start_row} < ROWS_L);
  assign start_base = 11'(start_row) * WPR_L;

  assign fetch_busy = (state != IDLE);
  assign wr_ready   = !reset && (state == IDLE) && !fetch_req && !pending && !swap_pending;
  assign wr_accept  = wr_valid && wr_ready;
  assign mem_we     = wr_accept && (wr_addr < WORDS_TOTAL);
  assign mem_wdata  = mem_we ? wr_data : 16'd0;

  always_comb begin
    mem_addr = 12'd0;
    if (state == FETCH)
      mem_addr = {fetch_page, row_base + {7'd0, k}};
    else if (wr_accept)
      mem_addr = {~display_page, wr_addr};
  end

  // Line-buffer write trails the read by one cycle to meet the memory latency
  assign lb_wr_en   = lb_en_q;
  assign lb_wr_addr = lb_en_q ? {bank, lb_idx} : 5'd0;
  assign lb_wr_data = lb_en_q ? mem_rdata : 16'd0;

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      k          <= 4'd0;
      lb_idx     <= 4'd0;
      lb_en_q    <= 1'b0;
      row_base   <= 11'd0;
      fetch_page <= 1'b0;
      bank       <= 1'b0;
    end else begin
      lb_en_q <= (state == FETCH);
      lb_idx  <= k;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state      <= FETCH;
            k          <= 4'd0;
            row_base   <= start_base;
            fetch_page <= display_page;
          end
        end
        FETCH: begin
          k <= k + 4'd1;
          if (k == LAST_K)
            state <= DRAIN;
        end
        DRAIN: begin
          bank <= ~bank;
          if (start_ok) begin
            state      <= FETCH;
            k          <= 4'd0;
            row_base   <= start_base;
            fetch_page <= display_page;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-deep request slot; a request that finds it full is lost and flagged
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      pending       <= 1'b0;
      pending_row   <= 7'd0;
      fetch_overrun <= 1'b0;
    end else if (state == IDLE) begin
      pending <= pending && fetch_req;
      if (pending && fetch_req)
        pending_row <= fetch_row;
    end else begin
      if (fetch_req && pending)
        fetch_overrun <= 1'b1;
      if (fetch_req && !pending) begin
        pending     <= 1'b1;
        pending_row <= fetch_row;
      end else if (pending && (state == DRAIN)) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      display_page <= 1'b0;
      swap_pending <= 1'b0;
    end else if (frame_start && (swap_pending || wr_frame_done)) begin
      display_page <= ~display_page;
      swap_pending <= 1'b0;
    end else if (wr_frame_done) begin
      swap_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_fetch_arbiter.sv
// Self-checking bench for fb_fetch_arbiter: directed scenarios followed by
// random traffic, all compared against a countdown-based transaction model.
module tb_fb_fetch_arbiter;

  localparam int W     = 10;
  localparam int NROWS = 120;

  logic        CLK_50 = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic        fetch_req = 1'b0;
  logic [6:0]  fetch_row = 7'd0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [10:0] wr_addr = 11'd0;
  logic [15:0] wr_data = 16'd0;
  logic        wr_frame_done = 1'b0;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        lb_wr_en;
  logic [4:0]  lb_wr_addr;
  logic [15:0] lb_wr_data;
  logic        display_page;
  logic        fetch_busy;
  logic        fetch_overrun;

  int checks = 0;
  int errors = 0;

  // Model: busy_left counts the remaining busy cycles of the current row copy
  int  busy_left, cur_row, slot_row;
  bit  cur_page, slot_full, bank, dp, swap, overrun;
  bit  m_acc, m_inr;
  logic [15:0] mem [4096];
  logic [15:0] ref_mem [4096];

  fb_fetch_arbiter #(.WORDS_PER_ROW(W), .ROWS(NROWS)) dut (
    .CLK_50(CLK_50), .reset(reset), .frame_start(frame_start),
    .fetch_req(fetch_req), .fetch_row(fetch_row),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_frame_done(wr_frame_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .lb_wr_en(lb_wr_en), .lb_wr_addr(lb_wr_addr), .lb_wr_data(lb_wr_data),
    .display_page(display_page), .fetch_busy(fetch_busy), .fetch_overrun(fetch_overrun)
  );

  always #10 CLK_50 = ~CLK_50;

  // Synchronous RAM with one cycle of read latency
  always @(posedge CLK_50) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task modelReset();
    busy_left = 0; cur_row = 0; slot_row = 0;
    cur_page = 0; slot_full = 0; bank = 0; dp = 0; swap = 0; overrun = 0;
  endtask

  task startRow(input int r, input bit p);
    if (r < NROWS) begin
      busy_left = W + 1;
      cur_row   = r;
      cur_page  = p;
    end
  endtask

  // Expected outputs for the current cycle, from model state and current inputs
  task checkAll();
    int j, row_addr, ea, la;
    bit fetching, ready, we, lb_en;
    logic [31:0] ld;
    j        = W + 1 - busy_left;
    fetching = busy_left > 1;
    row_addr = (cur_page ? 2048 : 0) + cur_row * W;
    ready    = !reset && busy_left == 0 && !fetch_req && !slot_full && !swap;
    m_acc    = wr_valid && ready;
    m_inr    = int'(wr_addr) < NROWS * W;
    we       = m_acc && m_inr;
    if (fetching) ea = row_addr + j;
    else if (m_acc) ea = (dp ? 0 : 2048) + int'(wr_addr);
    else ea = 0;
    lb_en = busy_left > 0 && j >= 1;
    la    = lb_en ? (bank ? 16 : 0) + j - 1 : 0;
    ld    = lb_en ? {16'd0, ref_mem[row_addr + j - 1]} : 32'd0;
    checkOutput("wr_ready", {31'd0, wr_ready}, {31'd0, ready});
    checkOutput("mem_addr", {20'd0, mem_addr}, ea);
    checkOutput("mem_we", {31'd0, mem_we}, {31'd0, we});
    checkOutput("mem_wdata", {16'd0, mem_wdata}, we ? {16'd0, wr_data} : 32'd0);
    checkOutput("lb_wr_en", {31'd0, lb_wr_en}, {31'd0, lb_en});
    checkOutput("lb_wr_addr", {27'd0, lb_wr_addr}, la);
    checkOutput("lb_wr_data", {16'd0, lb_wr_data}, ld);
    checkOutput("display_page", {31'd0, display_page}, {31'd0, dp});
    checkOutput("fetch_busy", {31'd0, fetch_busy}, {31'd0, busy_left > 0});
    checkOutput("fetch_overrun", {31'd0, fetch_overrun}, {31'd0, overrun});
  endtask

  // Advance the model across one rising edge using the inputs held during it
  task modelStep();
    bit dp_before, take;
    int take_row;
    dp_before = dp;
    if (m_acc && m_inr) ref_mem[(dp ? 0 : 2048) + int'(wr_addr)] = wr_data;
    if (busy_left > 0) begin
      take     = (busy_left == 1) && slot_full;
      take_row = slot_row;
      if (fetch_req) begin
        if (slot_full) overrun = 1;
        else begin slot_full = 1; slot_row = int'(fetch_row); end
      end
      if (take) slot_full = 0;
      busy_left--;
      if (busy_left == 0) begin
        bank = !bank;
        if (take) startRow(take_row, dp_before);
      end
    end else if (slot_full) begin
      take_row  = slot_row;
      slot_full = fetch_req;
      if (fetch_req) slot_row = int'(fetch_row);
      startRow(take_row, dp_before);
    end else if (fetch_req) begin
      startRow(int'(fetch_row), dp_before);
    end
    if (frame_start && (swap || wr_frame_done)) begin
      dp = !dp; swap = 0;
    end else if (wr_frame_done) begin
      swap = 1;
    end
  endtask

  task applyStimulus(input bit fr, input bit [6:0] row, input bit wv, input bit [10:0] wa,
                     input bit [15:0] wd, input bit fd, input bit fs);
    @(negedge CLK_50);
    fetch_req = fr; fetch_row = row; wr_valid = wv; wr_addr = wa; wr_data = wd;
    wr_frame_done = fd; frame_start = fs;
    #1;
    checkAll();
  endtask

  task advance();
    @(posedge CLK_50);
    modelStep();
  endtask

  task cyc(input bit fr, input bit [6:0] row, input bit wv, input bit [10:0] wa,
           input bit [15:0] wd, input bit fd, input bit fs);
    applyStimulus(fr, row, wv, wa, wd, fd, fs);
    advance();
  endtask

  task idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 7'd0, 0, 11'd0, 16'd0, 0, 0);
  endtask

  // Reset is raised mid-cycle so its asynchronous effect is visible at once
  task doReset();
    @(negedge CLK_50);
    reset = 1'b1;
    fetch_req = 0; fetch_row = 0; wr_valid = 0; wr_addr = 0; wr_data = 0;
    wr_frame_done = 0; frame_start = 0;
    #1;
    modelReset();
    checkAll();
    @(posedge CLK_50);
    @(negedge CLK_50);
    reset = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) begin
      mem[a]     = 16'($urandom);
      ref_mem[a] = mem[a];
    end
    modelReset();
    doReset();

    $display("[TB] single fetch of row 3, second request for row 119 queued");
    cyc(1, 7'd3, 0, 11'd0, 16'd0, 0, 0);
    #1 checkOutput("row3_first_addr", {20'd0, mem_addr}, 32'd30);
    idle(1);
    cyc(1, 7'd119, 0, 11'd0, 16'd0, 0, 0);
    idle(9);
    #1 checkOutput("row119_first_addr", {20'd0, mem_addr}, 32'd1190);
    checkOutput("row119_busy", {31'd0, fetch_busy}, 32'd1);
    idle(12);

    $display("[TB] three requests within one fetch");
    cyc(1, 7'd10, 0, 11'd0, 16'd0, 0, 0);
    cyc(1, 7'd11, 0, 11'd0, 16'd0, 0, 0);
    cyc(1, 7'd12, 0, 11'd0, 16'd0, 0, 0);
    #1 checkOutput("overrun_set", {31'd0, fetch_overrun}, 32'd1);
    idle(25);

    $display("[TB] loader write stalled behind a fetch");
    cyc(1, 7'd0, 1, 11'd5, 16'hA5A5, 0, 0);
    for (int i = 0; i < 11; i++) cyc(0, 7'd0, 1, 11'd5, 16'hA5A5, 0, 0);
    applyStimulus(0, 7'd0, 1, 11'd5, 16'hA5A5, 0, 0);
    checkOutput("stall_write_we", {31'd0, mem_we}, 32'd1);
    checkOutput("stall_write_addr", {20'd0, mem_addr}, 32'h805);
    checkOutput("stall_write_data", {16'd0, mem_wdata}, 32'hA5A5);
    advance();
    idle(2);

    $display("[TB] page swap with a fetch in flight");
    cyc(0, 7'd0, 0, 11'd0, 16'd0, 1, 0);
    applyStimulus(0, 7'd0, 1, 11'd40, 16'h1234, 0, 0);
    checkOutput("swap_pending_blocks", {31'd0, wr_ready}, 32'd0);
    advance();
    cyc(0, 7'd0, 1, 11'd40, 16'h1234, 0, 0);
    cyc(1, 7'd2, 0, 11'd0, 16'd0, 0, 0);
    cyc(0, 7'd0, 0, 11'd0, 16'd0, 0, 1);
    #1 checkOutput("swap_page", {31'd0, display_page}, 32'd1);
    checkOutput("inflight_page0", {20'd0, mem_addr}, 32'd21);
    idle(12);

    $display("[TB] reset during fetch cycle 4");
    cyc(1, 7'd7, 0, 11'd0, 16'd0, 0, 0);
    idle(4);
    doReset();
    idle(1);
    checkOutput("overrun_cleared", {31'd0, fetch_overrun}, 32'd0);
    cyc(1, 7'd7, 0, 11'd0, 16'd0, 0, 0);
    idle(1);
    applyStimulus(0, 7'd0, 0, 11'd0, 16'd0, 0, 0);
    checkOutput("post_reset_bank0", {27'd0, lb_wr_addr}, 32'd0);
    advance();
    idle(12);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 15) == 0, 7'($urandom_range(0, 127)),
          $urandom_range(0, 1) == 1, 11'($urandom_range(0, 1299)), 16'($urandom),
          $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0);
    end
    idle(15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
